// File: rtl/mul_approx_seq.sv
// mul_approx_seq: sequential shift-add unsigned multiplier dropping partial-product columns below trunc, with optional rounding bias.
module mul_approx_seq #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter int COMP           = 0,
  parameter int TW             = $clog2(2*WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [TW-1:0]        trunc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   o,
  output logic                 busy
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_a_sh, r_mask, r_bias, r_acc, r_o, w_sum;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0] r_cnt;
  logic w_last, w_accept;
  assign w_last    = r_cnt == CW'(N - 1);
  assign w_accept  = r_state == IDLE && in_valid;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign o         = r_o;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = CALC;
    if (r_state == CALC && w_last) w_next = DONE;
    if (r_state == DONE && out_ready) w_next = IDLE;
  end
  // r_a_sh tracks a << j for the lowest unconsumed b bit; r_mask keeps only columns >= trunc
  always_comb begin
    w_sum = r_acc;
    for (int k = 0; k < BITS_PER_CYCLE; k++)
      w_sum = w_sum + (r_b[k] ? ((r_a_sh << k) & r_mask) : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o    <= '0;
      r_acc  <= '0;
      r_a_sh <= '0;
      r_b    <= '0;
      r_mask <= '0;
      r_bias <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sh <= PW'(a);
      r_b    <= b;
      r_mask <= {PW{1'b1}} << trunc;
      r_bias <= (COMP != 0 && trunc != '0) ? (PW'(1) << (trunc - TW'(1))) : '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (r_state == CALC) begin
      r_acc  <= w_sum;
      r_a_sh <= r_a_sh << BITS_PER_CYCLE;
      r_b    <= r_b >> BITS_PER_CYCLE;
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) r_o <= w_sum + r_bias;
    end
  end
endmodule

// File: tb/tb_mul_approx_seq.sv
// tb_mul_approx_seq: directed checks of mul_approx_seq in three configurations (base, COMP=1, BPC=2).
module tb_mul_approx_seq;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready, in_ready, out_valid, busy;
  logic [7:0] a, b;
  logic [3:0] trunc;
  logic [15:0] o;
  logic in_ready1, out_valid1, busy1;
  logic [15:0] o1;
  logic in_valid2, out_ready2, in_ready2, out_valid2, busy2;
  logic [7:0] a2, b2;
  logic [3:0] trunc2;
  logic [15:0] o2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_approx_seq #(.WIDTH(8), .BITS_PER_CYCLE(1), .COMP(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .trunc(trunc),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .busy(busy));
  mul_approx_seq #(.WIDTH(8), .BITS_PER_CYCLE(1), .COMP(1)) dut_comp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b), .trunc(trunc),
    .out_valid(out_valid1), .out_ready(out_ready), .o(o1), .busy(busy1));
  mul_approx_seq #(.WIDTH(8), .BITS_PER_CYCLE(2), .COMP(0)) dut_bpc2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2), .trunc(trunc2),
    .out_valid(out_valid2), .out_ready(out_ready2), .o(o2), .busy(busy2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction into the base and COMP duts; lat counts cycles from the in_valid cycle to out_valid.
  task automatic do_txn(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] tt,
                        output logic [15:0] r0, output logic [15:0] r1, output int lat, output logic rdy_seen);
    a = ta; b = tb; trunc = tt; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0; rdy_seen = 1'b0;
    do begin
      step();
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0; a = ~ta; b = ~tb; trunc = ~tt;
      end
      if (!out_valid) rdy_seen = rdy_seen | in_ready;
    end while (!out_valid && lat < 50);
    r0 = o; r1 = o1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if (o !== 16'd0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: o=%0d out_valid=%b busy=%b in_ready=%b, want 0 0 0 1", o, out_valid, busy, in_ready);
    end
  endtask

  task automatic test_exact();
    logic [15:0] r0, r1;
    int lat;
    logic rs;
    do_txn(8'd200, 8'd150, 4'd0, r0, r1, lat, rs);
    checks++;
    if (r0 !== 16'd30000) begin failures++; $display("FAIL exact_o: got %0d want 30000", r0); end
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL exact_latency: got %0d want 9", lat); end
    checks++;
    if (rs !== 1'b0) begin failures++; $display("FAIL exact_in_ready: in_ready seen high during calc"); end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL exact_after: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_truncation();
    logic [7:0]  va [7] = '{8'd255, 8'd3, 8'd0,  8'd255, 8'd255, 8'd1, 8'd200};
    logic [7:0]  vb [7] = '{8'd255, 8'd5, 8'd77, 8'd255, 8'd255, 8'd1, 8'd150};
    logic [3:0]  vt [7] = '{4'd8,   4'd3, 4'd4,  4'd15,  4'd14,  4'd1, 4'd0};
    logic [15:0] e0 [7] = '{16'd63232, 16'd8,  16'd0, 16'd0,     16'd16384, 16'd0, 16'd30000};
    logic [15:0] e1 [7] = '{16'd63360, 16'd12, 16'd8, 16'd16384, 16'd24576, 16'd1, 16'd30000};
    logic [15:0] r0, r1;
    int lat;
    logic rs;
    for (int i = 0; i < 7; i++) begin
      do_txn(va[i], vb[i], vt[i], r0, r1, lat, rs);
      checks++;
      if (r0 !== e0[i]) begin
        failures++; $display("FAIL trunc_comp0[%0d]: got %0d want %0d", i, r0, e0[i]);
      end
      checks++;
      if (r1 !== e1[i]) begin
        failures++; $display("FAIL trunc_comp1[%0d]: got %0d want %0d", i, r1, e1[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    a = 8'd12; b = 8'd11; trunc = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    a = 8'd99; b = 8'd98;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    checks++;
    if (!out_valid) begin failures++; $display("FAIL bp_timeout: out_valid never rose"); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (o !== 16'd132 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++; bad++;
        if (bad < 4) $display("FAIL bp_hold[%0d]: o=%0d out_valid=%b in_ready=%b want 132 1 0", i, o, out_valid, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || o !== 16'd132) begin
      failures++; $display("FAIL bp_release: out_valid=%b in_ready=%b o=%0d want 0 1 132", out_valid, in_ready, o);
    end
    n = 0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid || busy) n++; end
    checks++;
    if (n !== 0) begin failures++; $display("FAIL bp_no_dup: %0d busy/valid cycles after release, want 0", n); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_calc();
    logic [15:0] r0, r1;
    int lat;
    logic rs;
    int n;
    a = 8'd99; b = 8'd99; trunc = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (o !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset: o=%0d out_valid=%b in_ready=%b busy=%b want 0 0 1 0", o, out_valid, in_ready, busy);
    end
    n = 0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid) n++; end
    checks++;
    if (n !== 0) begin failures++; $display("FAIL mid_reset_ghost: out_valid seen %0d cycles, want 0", n); end
    do_txn(8'd17, 8'd13, 4'd0, r0, r1, lat, rs);
    checks++;
    if (r0 !== 16'd221 || lat !== 9) begin
      failures++; $display("FAIL post_reset_txn: o=%0d lat=%0d want 221 9", r0, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int acc [$];
    int outs;
    a2 = 8'd255; b2 = 8'd255; trunc2 = 4'd0; in_valid2 = 1'b1; out_ready2 = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (!out_valid2 && lat < 50);
    checks++;
    if (lat !== 5 || o2 !== 16'd65025) begin
      failures++; $display("FAIL bpc2_first: lat=%0d o=%0d want 5 65025", lat, o2);
    end
    outs = 0;
    for (int c = 0; c < 30; c++) begin
      if (in_ready2 && in_valid2) acc.push_back(c);
      step();
      if (out_valid2) begin
        outs++;
        checks++;
        if (o2 !== 16'd65025) begin failures++; $display("FAIL bpc2_o[%0d]: got %0d want 65025", c, o2); end
      end
    end
    in_valid2 = 1'b0;
    checks++;
    if (acc.size() < 4 || outs < 4) begin
      failures++; $display("FAIL b2b_count: accepts=%0d outputs=%0d want >=4", acc.size(), outs);
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] !== 6) begin
        failures++; $display("FAIL b2b_spacing[%0d]: got %0d want 6", i, acc[i] - acc[i-1]);
      end
    end
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; trunc = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; trunc2 = '0;
    test_reset();
    test_exact();
    test_truncation();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
